// File: rtl/collision_score_unit.sv
// Bird/building collision detection, lives and score keeping for one game session.
// Optional macro SCORE_STAGE_BONUS_EN: +16 score whenever the stage changes between frames.
module collision_score_unit #(
  parameter int unsigned LIVES_INIT      = 3,
  parameter int unsigned SCORE_W         = 16,
  parameter int unsigned COOLDOWN_FRAMES = 60
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               startOfFrame,
  input  logic               start,
  input  logic               drawing_bird,
  input  logic               drawing_building_1,
  input  logic               drawing_building_2,
  input  logic [31:0]        stage,
  output logic               collision_building_1,
  output logic               collision_building_2,
  output logic               bird_hit,
  output logic [SCORE_W-1:0] score,
  output logic [3:0]         lives,
  output logic               playing,
  output logic               game_over
);

  localparam int unsigned SUM_W   = SCORE_W + 6;
  localparam int unsigned CD_W    = 8;
  localparam logic [3:0]  LIVES_LOAD = 4'(LIVES_INIT);
  localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN_FRAMES);
  localparam logic [SUM_W-1:0] SCORE_MAX = SUM_W'({SCORE_W{1'b1}});

  typedef enum logic [1:0] {IDLE, PLAY, HIT, OVER} state_t;

  state_t            state, state_n;
  logic [CD_W-1:0]   cooldown, cooldown_n;
  logic [3:0]        lives_n;
  logic [SCORE_W-1:0] score_n;
  logic              hit1, hit2, hit1_n, hit2_n;
  logic              col1_n, col2_n, bird_hit_n;
  logic              ovl1, ovl2;
  logic [5:0]        inc;
  logic [SUM_W-1:0]  sum;

`ifdef SCORE_STAGE_BONUS_EN
  logic [31:0] stage_q;
`else
  logic stage_unused;
  assign stage_unused = ^stage;
`endif

  // Next-state, next-score/lives and pulse generation
  always_comb begin
    state_n    = state;
    lives_n    = lives;
    score_n    = score;
    cooldown_n = cooldown;
    col1_n     = 1'b0;
    col2_n     = 1'b0;
    bird_hit_n = 1'b0;
    inc        = 6'd0;
    sum        = '0;
    ovl1       = drawing_bird & drawing_building_1;
    ovl2       = drawing_bird & drawing_building_2;
    // Overlap on the frame-start cycle belongs to the new frame
    hit1_n     = startOfFrame ? ovl1 : (hit1 | ovl1);
    hit2_n     = startOfFrame ? ovl2 : (hit2 | ovl2);

    case (state)
      IDLE: begin
        if (start) begin
          state_n    = PLAY;
          lives_n    = LIVES_LOAD;
          score_n    = '0;
          cooldown_n = '0;
          hit1_n     = 1'b0;
          hit2_n     = 1'b0;
        end
      end
      PLAY: begin
        if (startOfFrame) begin
          if (hit1 | hit2) begin
            col1_n     = hit1;
            col2_n     = hit2;
            bird_hit_n = 1'b1;
            lives_n    = lives - 4'd1;
            cooldown_n = CD_LOAD;
            state_n    = (lives <= 4'd1) ? OVER : HIT;
          end else begin
            inc = 6'd1;
          end
`ifdef SCORE_STAGE_BONUS_EN
          if (stage != stage_q) inc = inc + 6'd16;
`endif
          sum     = SUM_W'(score) + SUM_W'(inc);
          score_n = (sum > SCORE_MAX) ? SCORE_W'(SCORE_MAX) : SCORE_W'(sum);
        end
      end
      HIT: begin
        if (startOfFrame) begin
          cooldown_n = cooldown - CD_W'(1);
          if (cooldown <= CD_W'(1)) begin
            cooldown_n = '0;
            state_n    = PLAY;
          end
        end
      end
      OVER: begin
        if (start) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state                <= IDLE;
      lives                <= LIVES_LOAD;
      score                <= '0;
      cooldown             <= '0;
      hit1                 <= 1'b0;
      hit2                 <= 1'b0;
      collision_building_1 <= 1'b0;
      collision_building_2 <= 1'b0;
      bird_hit             <= 1'b0;
      playing              <= 1'b0;
      game_over            <= 1'b0;
    end else begin
      state                <= state_n;
      lives                <= lives_n;
      score                <= score_n;
      cooldown             <= cooldown_n;
      hit1                 <= hit1_n;
      hit2                 <= hit2_n;
      collision_building_1 <= col1_n;
      collision_building_2 <= col2_n;
      bird_hit             <= bird_hit_n;
      playing              <= (state_n == PLAY) || (state_n == HIT);
      game_over            <= (state_n == OVER);
    end
  end

`ifdef SCORE_STAGE_BONUS_EN
  // Stage seen at the previous frame start
  always_ff @(posedge clk) begin
    if (reset)             stage_q <= '0;
    else if (startOfFrame) stage_q <= stage;
  end
`endif

endmodule

// File: doc/collision_score_unit.md
COLLISION_SCORE_UNIT -- requirements
Module: collision_score_unit

Interface
REQ-001 SHALL have parameter LIVES_INIT, default 3: lives loaded at reset and at game start (1..15).
REQ-002 SHALL have parameter SCORE_W, default 16: width of score counter.
REQ-003 SHALL have parameter COOLDOWN_FRAMES, default 60: invulnerability frames after a hit (1..255).
REQ-004 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port startOfFrame  input  1  one-cycle pulse marking first pixel of each frame.
REQ-007 SHALL have port start  input  1  player start request, level-sampled.
REQ-008 SHALL have port drawing_bird  input  1  bird pixel active at current pxl.
REQ-009 SHALL have ports drawing_building_1 / drawing_building_2  input  1 each  building pixel active.
REQ-010 SHALL have port stage  input  32  current stage from building mover.
REQ-011 SHALL have ports collision_building_1 / collision_building_2  output  1 each  one-cycle hit pulse to building unit.
REQ-012 SHALL have port bird_hit  output  1  one-cycle pulse when a life is lost.
REQ-013 SHALL have port score  output  SCORE_W  current score.
REQ-014 SHALL have port lives  output  4  remaining lives.
REQ-015 SHALL have ports playing / game_over  output  1 each  state flags.

Function
REQ-016 SHALL implement FSM IDLE, PLAY, HIT, OVER; playing=1 in PLAY or HIT; game_over=1 in OVER only.
REQ-017 IDLE -> PLAY when start=1; lives<=LIVES_INIT, score<=0, cooldown<=0 on that edge.
REQ-018 Sticky flags hit1/hit2 SHALL set on any cycle with drawing_bird && drawing_building_k; cleared at startOfFrame.
REQ-019 Overlap in the same cycle as startOfFrame SHALL count toward the new frame (flag cleared then set).
REQ-020 At startOfFrame in PLAY with hit1|hit2: next cycle collision_building_k=hit_k (both may pulse), bird_hit=1, lives decremented by exactly 1, cooldown<=COOLDOWN_FRAMES, state->HIT.
REQ-021 Hit with lives==1: lives->0, state->OVER instead of HIT; pulses still emitted.
REQ-022 In HIT, flags SHALL be ignored (no pulses); cooldown decrements each startOfFrame; at startOfFrame with cooldown==1 -> PLAY.
REQ-023 score SHALL increment by 1 at each startOfFrame in PLAY with no hit evaluated that frame; HIT/IDLE/OVER do not score.
REQ-024 score SHALL saturate at 2^SCORE_W-1 (no wrap).
REQ-025 OVER -> IDLE when start=1; score and lives hold in OVER and IDLE until next game start.
REQ-026 All outputs SHALL be registered; hit pulses exactly one cycle wide, one cycle after startOfFrame.
REQ-027 start in PLAY/HIT SHALL be ignored.

Reset
REQ-028 On reset: state=IDLE, lives=LIVES_INIT, score=0, cooldown=0, flags=0, all pulse outputs=0, playing=0, game_over=0.
REQ-029 Reset SHALL take precedence over every other event in the same cycle, including mid-frame and mid-cooldown.

Configuration
REQ-030 Macro SCORE_STAGE_BONUS_EN defined: on any startOfFrame in PLAY where stage differs from value registered at previous startOfFrame, score SHALL add 16 (saturating) in addition to REQ-023.
REQ-031 Macro undefined: stage input unused, no bonus, no stage register synthesized.

Verification
REQ-032 Reset, start=1 one cycle -> playing=1, lives=3, score=0; 5 clean frames -> score=5.
REQ-033 Bird+building_1 overlap 1 cycle mid-frame -> next startOfFrame+1: collision_building_1=1 one cycle, bird_hit=1, lives=2, state HIT.
REQ-034 Both buildings overlap same frame -> both collision pulses same cycle, lives decrements by 1 only.
REQ-035 Overlap every frame during cooldown (COOLDOWN_FRAMES=3) -> no pulses for 3 frames, 4th frame overlap causes hit.
REQ-036 Three hits spaced past cooldown -> lives=0, game_over=1; start -> IDLE; start -> PLAY with lives=3, score=0.
REQ-037 With SCORE_STAGE_BONUS_EN, stage 0->1 in PLAY -> score +17 that frame; without macro -> +1.
